// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 machine and its peripheral taps.
package sap1_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  // Ceiling log2, for tools without $clog2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; push is accepted when full if a pop
// happens on the same edge.
module byte_fifo
  import sap1_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  byte_t                   din,
  output byte_t                   dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  byte_t       mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage is only read while non-empty, so it needs no reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/out_port_capture.sv
// Captures SAP-1 output-register writes into a FIFO for a host consumer and latches
// the CPU halt indication.
module out_port_capture
  import sap1_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter bit          USE_STROBE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  byte_t                 out_reg,
  input  logic                  out_strobe,
  input  logic                  halted,
  output byte_t                 rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  halt_seen,
  output logic                  drain_done
);

  byte_t last_val;
  logic  cap_event;
  logic  fifo_full;
  logic  fifo_empty;

  assign cap_event  = USE_STROBE ? out_strobe : (out_reg != last_val);
  assign rd_valid   = !fifo_empty;
  assign drain_done = halt_seen && fifo_empty;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cap_event),
    .pop     (rd_ready),
    .din     (out_reg),
    .dout    (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_val  <= '0;
      overflow  <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      // last_val follows every event, even a dropped one, so nothing is re-captured.
      if (cap_event) last_val <= out_reg;
      if (cap_event && fifo_full && !(rd_ready && rd_valid)) overflow <= 1'b1;
      if (halted) halt_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_port_capture.sv
// Directed self-checking bench for out_port_capture (change-detect and strobe variants).
module tb_out_port_capture;
  import sap1_pkg::*;

  logic       clk;
  logic       reset_n;
  byte_t      out_reg;
  logic       out_strobe;
  logic       halted;
  byte_t      rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       overflow;
  logic       halt_seen;
  logic       drain_done;

  byte_t      b_out_reg;
  logic       b_strobe;
  logic       b_ready;
  logic       b_halted;
  byte_t      b_rd_data;
  logic       b_rd_valid;
  logic [3:0] b_count;
  logic       b_overflow;
  logic       b_halt_seen;
  logic       b_drain_done;

  int n_tests;
  int n_fail;

  out_port_capture #(.DEPTH(8), .USE_STROBE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .out_reg(out_reg), .out_strobe(out_strobe),
    .halted(halted), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .overflow(overflow), .halt_seen(halt_seen), .drain_done(drain_done)
  );

  out_port_capture #(.DEPTH(8), .USE_STROBE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .out_reg(b_out_reg), .out_strobe(b_strobe),
    .halted(b_halted), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_ready),
    .count(b_count), .overflow(b_overflow), .halt_seen(b_halt_seen),
    .drain_done(b_drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one entry from the change-detect DUT, checking the head byte first.
  task automatic pop_a(input string tag, input int exp);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; out_reg = 8'h00; out_strobe = 1'b0; halted = 1'b0; rd_ready = 1'b0;
    b_out_reg = 8'h00; b_strobe = 1'b0; b_ready = 1'b0; b_halted = 1'b0;

    #2;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_halt", halt_seen, 0);
    check("rst_drain", drain_done, 0);
    check("rst_s_count", b_count, 0);

    @(posedge clk); #1; reset_n = 1'b1;
    tick();
    check("idle_valid", rd_valid, 0);
    out_reg = 8'h05;
    tick();
    check("lat_valid", rd_valid, 1);
    check("lat_data", rd_data, 8'h05);
    check("lat_count", count, 1);
    pop_a("pop5", 8'h05);
    check("pop_valid", rd_valid, 0);
    check("pop_count", count, 0);

    // Repeated values collapse: 1,1,2,2,3 -> 1,2,3.
    out_reg = 8'h01; tick();
    out_reg = 8'h01; tick();
    out_reg = 8'h02; tick();
    out_reg = 8'h02; tick();
    out_reg = 8'h03; tick();
    check("dup_count", count, 3);
    pop_a("dup_pop0", 1);
    pop_a("dup_pop1", 2);
    pop_a("dup_pop2", 3);
    check("dup_empty", rd_valid, 0);

    // Ten distinct values into an 8-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      out_reg = 8'h10 + 8'(i);
      tick();
    end
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) pop_a($sformatf("ovf_pop%0d", i), 8'h10 + i);
    check("ovf_drained", count, 0);
    check("ovf_sticky", overflow, 1);

    #3; reset_n = 1'b0; out_reg = 8'h00; #1;
    check("rst2_ovf", overflow, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    // Full FIFO with simultaneous push and pop keeps count and accepts the new byte.
    for (int i = 0; i < 8; i++) begin
      out_reg = 8'h20 + 8'(i);
      tick();
    end
    check("full_count", count, 8);
    check("full_ovf", overflow, 0);
    out_reg = 8'h28; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pp_count", count, 8);
    check("pp_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) pop_a($sformatf("pp_pop%0d", i), 8'h21 + i);
    check("pp_drained", count, 0);

    // Strobe variant: out_reg changes alone are ignored; each pulse queues a byte.
    b_out_reg = 8'h09; tick();
    check("stb_nochg", b_count, 0);
    b_out_reg = 8'h07;
    for (int i = 0; i < 3; i++) begin
      b_strobe = 1'b1; tick();
      b_strobe = 1'b0; tick();
    end
    check("stb_count", b_count, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stb_pop%0d", i), b_rd_data, 8'h07);
      b_ready = 1'b1; tick(); b_ready = 1'b0;
    end
    check("stb_empty", b_rd_valid, 0);

    // Halt with two entries queued, then drain.
    out_reg = 8'h31; tick();
    out_reg = 8'h32; tick();
    check("halt_count", count, 2);
    halted = 1'b1; tick(); halted = 1'b0;
    check("halt_seen", halt_seen, 1);
    check("halt_drain0", drain_done, 0);
    pop_a("halt_pop0", 8'h31);
    check("halt_drain1", drain_done, 0);
    pop_a("halt_pop1", 8'h32);
    check("halt_drain2", drain_done, 1);
    check("halt_sticky", halt_seen, 1);
    out_reg = 8'h33; tick();
    check("late_cap", count, 1);
    check("late_drain", drain_done, 0);

    // Mid-cycle async reset drops state without a clock edge.
    #3; reset_n = 1'b0; #1;
    check("arst_count", count, 0);
    check("arst_halt", halt_seen, 0);
    check("arst_drain", drain_done, 0);
    check("arst_valid", rd_valid, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    tick();
    check("post_rst_cap", rd_data, 8'h33);
    check("post_rst_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
